// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage-register state encoding and the canonical RISC-V NOP.
// Imported by the pipeline stage registers and their perf counters.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // ADDI x0,x0,0 -- for stages whose bubble must decode as a real instruction
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        case (s)
            ST_ONE:  state_occupancy = 2'd1;
            ST_TWO:  state_occupancy = 2'd2;
            default: state_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance-debug events; cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, flush/hold controls and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter bit                 SKID_EN   = 1'b1,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_accept;
    logic w_emit;

    assign w_main_valid = (r_state != ST_EMPTY);
    assign w_skid_valid = (r_state == ST_TWO);

    // With the skid buffer, ready depends only on a flop plus hold, so the
    // downstream ready never propagates combinationally upstream.
    generate
        if (SKID_EN) begin : g_skid_ready
            assign in_ready_o = ~w_skid_valid & ~hold_i;
        end else begin : g_flow_ready
            assign in_ready_o = (~w_main_valid | out_ready_i) & ~hold_i;
        end
    endgenerate

    assign w_accept = in_valid_i & in_ready_o;
    assign w_emit   = w_main_valid & out_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main_data;
        w_skid_nxt  = r_skid_data;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = NOP_VALUE;
            w_skid_nxt  = NOP_VALUE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        w_main_nxt = in_data_i;
                    end else if (w_accept && SKID_EN) begin
                        w_state_nxt = ST_TWO;
                        w_skid_nxt  = in_data_i;
                    end else if (w_emit) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Skid is always the younger entry, so it moves up into main.
                    if (w_emit) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid_data;
                        w_skid_nxt  = NOP_VALUE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_EMPTY;
            r_main_data <= NOP_VALUE;
            r_skid_data <= NOP_VALUE;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_nxt;
            r_skid_data <= w_skid_nxt;
        end
    end

    assign out_valid_o = w_main_valid;
    assign out_data_o  = w_main_valid ? r_main_data : NOP_VALUE;
    assign occupancy_o = state_occupancy(r_state);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_main_valid & ~out_ready_i),
        .cnt_o (stall_cnt_o)
    );

endmodule
